// File: rtl/pipe_issue_pkg.sv
// pipe_issue_pkg: shared types and constants for the pipe_issue block.
// Holds the FSM state enum, the instruction word layout, the sizing
// constants, and small helpers for decoding a slot and clamping the length.
package pipe_issue_pkg;

    // Sizing
    localparam int PROG_DEPTH   = 16;  // program memory slots
    localparam int HAZ_DEPTH    = 2;   // scoreboard depth in issue cycles
    localparam int DRAIN_CYCLES = 2;   // write-back drain after the last issue

    localparam int INSTR_W   = 24;
    localparam int FUNC_W    = 4;
    localparam int REG_W     = 4;
    localparam int ADDR_W    = 8;
    localparam int OUT_REG_W = 16;
    localparam int PC_W      = $clog2(PROG_DEPTH);
    localparam int LEN_W     = PC_W + 1;
    localparam int DRAIN_W   = 2;
    localparam int STALL_W   = 8;

    // Instruction word field positions (LSB of each field)
    localparam int FUNC_LSB = 20;
    localparam int RS1_LSB  = 16;
    localparam int RS2_LSB  = 12;
    localparam int RD_LSB   = 8;
    localparam int ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [ADDR_W-1:0] addr;
    } instr_t;

    // Split a raw program word into its fields.
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] w);
        instr_t i;
        i.func = w[FUNC_LSB +: FUNC_W];
        i.rs1  = w[RS1_LSB  +: REG_W];
        i.rs2  = w[RS2_LSB  +: REG_W];
        i.rd   = w[RD_LSB   +: REG_W];
        i.addr = w[ADDR_LSB +: ADDR_W];
        return i;
    endfunction

    // Index of the last slot to issue; lengths above the memory depth clamp
    // to a full program. Only called with len > 0.
    function automatic logic [PC_W-1:0] last_slot(input logic [LEN_W-1:0] len);
        logic [LEN_W-1:0] eff;
        eff = (len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : len;
        return PC_W'(eff - LEN_W'(1));
    endfunction

endpackage

// File: rtl/pipe_issue_scoreboard.sv
// pipe_issue_scoreboard: remembers the destination registers of the last
// HAZ_DEPTH issue cycles and flags a read-after-write hazard when the
// instruction waiting at the PC reads any of them. Shifts every cycle; a
// cycle that issues nothing shifts in an invalid entry.
module pipe_issue_scoreboard
    import pipe_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [REG_W-1:0] push_rd,
    input  logic [REG_W-1:0] chk_rs1,
    input  logic [REG_W-1:0] chk_rs2,
    output logic             hazard
);

    logic [HAZ_DEPTH-1:0]            vld_q, vld_d;
    logic [HAZ_DEPTH-1:0][REG_W-1:0] rd_q,  rd_d;

    // Shift: entry 0 is last cycle's issue, entry 1 the cycle before.
    always_comb begin
        vld_d[0] = push_valid;
        rd_d[0]  = push_rd;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
        end
    end

    // Hazard when either source matches a still-valid in-flight destination.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (vld_q[i] && ((rd_q[i] == chk_rs1) || (rd_q[i] == chk_rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    // Scoreboard register; reset clears all entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            rd_q  <= '0;
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
        end
    end

endmodule

// File: rtl/pipe_issue.sv
// pipe_issue: in-order issue stage. Holds a 16-slot program, walks it from
// slot 0 on start, presents one instruction per cycle to the ALU pipeline on
// registered outputs, drains two cycles for the last write-back, then pulses
// done. Define PIPE_ISSUE_HAZARD_EN to add the RAW scoreboard and STALL
// behaviour; without it every RUN cycle issues and stall_cnt reads 0.
module pipe_issue
    import pipe_issue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     prog_len,
    input  logic                 ld_en,
    input  logic [PC_W-1:0]      ld_addr,
    input  logic [INSTR_W-1:0]   ld_data,
    output logic [OUT_REG_W-1:0] rs1,
    output logic [OUT_REG_W-1:0] rs2,
    output logic [OUT_REG_W-1:0] rd,
    output logic [FUNC_W-1:0]    func,
    output logic [ADDR_W-1:0]    addr,
    output logic                 issue_valid,
    output logic                 busy,
    output logic                 done,
    output logic [STALL_W-1:0]   stall_cnt
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     last_q, last_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    logic                issue_valid_q, issue_valid_d;
    logic [FUNC_W-1:0]   func_q, func_d;
    logic [REG_W-1:0]    rs1_q, rs1_d;
    logic [REG_W-1:0]    rs2_q, rs2_d;
    logic [REG_W-1:0]    rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [INSTR_W-1:0]  prog_mem_q [PROG_DEPTH];
    logic                mem_we;
    instr_t              cur;
    logic                start_acc;
    logic                issue;
    logic                hazard;

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign start_acc = (state_q == ST_IDLE) && start;
    assign cur       = decode_instr(prog_mem_q[pc_q]);

    // Loads are accepted only while idle; reset blocks them too.
    assign mem_we = ld_en && !busy && !rst;

    // Program memory write port.
    // NOTE: the program store has no reset -- its contents must survive rst,
    // and leaving it out keeps it mappable onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            prog_mem_q[ld_addr] <= ld_data;
        end
    end

`ifdef PIPE_ISSUE_HAZARD_EN
    pipe_issue_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue),
        .push_rd    (issue ? cur.rd : '0),
        .chk_rs1    (cur.rs1),
        .chk_rs2    (cur.rs2),
        .hazard     (hazard)
    );
`else
    // Nothing ever stalls, so STALL is unreachable and folds away.
    assign hazard = 1'b0;
`endif

    // Next-state, PC and drain-counter logic; decides whether this cycle issues.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        drain_d = drain_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    pc_d = '0;
                    if (prog_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        last_d  = last_slot(prog_len);
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_STALL: begin
                if (hazard) begin
                    state_d = ST_STALL;
                end else begin
                    issue = 1'b1;
                    pc_d  = pc_q + PC_W'(1);
                    if (pc_q == last_q) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output stage: the issued slot, or all zeros on a bubble / idle cycle.
    always_comb begin
        issue_valid_d = issue;
        func_d        = '0;
        rs1_d         = '0;
        rs2_d         = '0;
        rd_d          = '0;
        addr_d        = '0;
        if (issue) begin
            func_d = cur.func;
            rs1_d  = cur.rs1;
            rs2_d  = cur.rs2;
            rd_d   = cur.rd;
            addr_d = cur.addr;
        end
    end

    // Control and output registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            last_q        <= '0;
            drain_q       <= '0;
            issue_valid_q <= 1'b0;
            func_q        <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            last_q        <= last_d;
            drain_q       <= drain_d;
            issue_valid_q <= issue_valid_d;
            func_q        <= func_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            addr_q        <= addr_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign func        = func_q;
    assign rs1         = OUT_REG_W'(rs1_q);
    assign rs2         = OUT_REG_W'(rs2_q);
    assign rd          = OUT_REG_W'(rd_q);
    assign addr        = addr_q;

`ifdef PIPE_ISSUE_HAZARD_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               bubble;

    assign bubble = ((state_q == ST_RUN) || (state_q == ST_STALL)) && hazard;

    // Stall counter: cleared on an accepted start, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (bubble && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_issue.sv
// tb_pipe_issue: directed bench for pipe_issue. Loads small programs, runs
// them, records every issue and the done pulse with their cycle offsets from
// the accepted start, and compares against hand-derived timelines. Expected
// timings follow the build: hazard stalls apply only with PIPE_ISSUE_HAZARD_EN.
module tb_pipe_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  prog_len;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [23:0] ld_data;
    logic [15:0] rs1, rs2, rd;
    logic [3:0]  func;
    logic [7:0]  addr;
    logic        issue_valid, busy, done;
    logic [7:0]  stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-run record
    logic [23:0] iss_w[$];
    int          iss_k[$];
    int          done_k;
    logic [7:0]  stall_at_done;
    int          zero_bad;
    int          ext_bad;
    logic        busy_after;

    // Cycle offsets (from the start edge) that depend on the build.
`ifdef PIPE_ISSUE_HAZARD_EN
    localparam int B_K1 = 4, B_DONE = 6, B_STALL = 2;
    localparam int C_K2 = 4, C_DONE = 6, C_STALL = 1;
`else
    localparam int B_K1 = 2, B_DONE = 4, B_STALL = 0;
    localparam int C_K2 = 3, C_DONE = 5, C_STALL = 0;
`endif

    pipe_issue dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_len    (prog_len),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .issue_valid (issue_valid),
        .busy        (busy),
        .done        (done),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mk(input logic [3:0] f, input logic [3:0] r1,
                                       input logic [3:0] r2, input logic [3:0] d,
                                       input logic [7:0] a);
        return {f, r1, r2, d, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [23:0] w);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = w;
        step();
        ld_en   = 1'b0;
    endtask

    // Start a run and record it until done (bounded). With poke set, a load
    // to slot 0 and a second start are attempted while the run is busy.
    task automatic run_prog(input logic [4:0] len, input bit poke);
        iss_w.delete();
        iss_k.delete();
        done_k   = -1;
        zero_bad = 0;
        ext_bad  = 0;
        stall_at_done = 8'hxx;
        prog_len = len;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (issue_valid === 1'b1) begin
                iss_w.push_back({func, rs1[3:0], rs2[3:0], rd[3:0], addr});
                iss_k.push_back(k);
                if ((rs1[15:4] | rs2[15:4] | rd[15:4]) !== 12'h0) ext_bad++;
            end else if ({func, rs1, rs2, rd, addr} !== 60'h0) begin
                zero_bad++;
            end
            if (done === 1'b1) begin
                done_k        = k;
                stall_at_done = stall_cnt;
                break;
            end
            if (poke && k == 1) begin
                ld_en = 1'b1; ld_addr = 4'd0; ld_data = 24'hFFFFFF;
            end else if (poke && k == 2) begin
                ld_en = 1'b0; start = 1'b1; prog_len = 5'd5;
            end else begin
                ld_en = 1'b0; start = 1'b0;
            end
            step();
        end
        ld_en = 1'b0;
        start = 1'b0;
        step();
        busy_after = busy;
    endtask

    task automatic check_run(input string tag, input int n_exp, input int done_exp,
                             input int stall_exp);
        check({tag, "_issues"},    iss_k.size(), n_exp);
        check({tag, "_done_k"},    done_k, done_exp);
        check({tag, "_stall_cnt"}, {24'h0, stall_at_done}, stall_exp);
        check({tag, "_bubble_zero"}, zero_bad, 0);
        check({tag, "_zero_ext"},  ext_bad, 0);
        check({tag, "_idle_after"}, busy_after, 1'b0);
    endtask

    task automatic issue_at(input string tag, input int idx, input int exp_k,
                            input logic [23:0] exp_w);
        int          k_obs;
        logic [23:0] w_obs;
        if (idx < iss_k.size()) begin
            k_obs = iss_k[idx];
            w_obs = iss_w[idx];
        end else begin
            k_obs = -1;
            w_obs = 'x;
        end
        check({tag, "_cycle"}, k_obs, exp_k);
        check({tag, "_word"},  {8'h0, w_obs}, {8'h0, exp_w});
    endtask

    initial begin
        logic [23:0] a0, a1, a2, b0, b1, c0, c1, c2;
        int          bad;
        int          seen;

        a0 = mk(4'h1, 4'd7, 4'd2, 4'd9,  8'h10);  // add r7,r2 -> r9
        a1 = mk(4'h6, 4'd5, 4'd0, 4'd10, 8'h11);  // shr r5 -> r10
        a2 = mk(4'h9, 4'd8, 4'd4, 4'd11, 8'h12);  // div r8,r4 -> r11
        b0 = mk(4'h1, 4'd7, 4'd2, 4'd9,  8'h20);  // writes r9
        b1 = mk(4'h2, 4'd9, 4'd3, 4'd12, 8'h21);  // reads r9 next cycle
        c0 = mk(4'h1, 4'd7, 4'd2, 4'd9,  8'h30);  // writes r9
        c1 = mk(4'h3, 4'd1, 4'd4, 4'd13, 8'h31);  // independent
        c2 = mk(4'h5, 4'd6, 4'd9, 4'd14, 8'h32);  // reads r9 two cycles on

        rst = 1'b1; start = 1'b0; prog_len = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        step();
        check("reset_busy",      busy, 1'b0);
        check("reset_outs_zero", |{func, rs1, rs2, rd, addr, issue_valid, done}, 1'b0);
        check("reset_stall_cnt", stall_cnt, 8'h0);
        rst = 1'b0;
        step();

        // Independent program; then reset must beat start and ld_en together.
        load(4'd0, a0); load(4'd1, a1); load(4'd2, a2);
        rst = 1'b1; start = 1'b1; prog_len = 5'd3;
        ld_en = 1'b1; ld_addr = 4'd0; ld_data = 24'hFFFFFF;
        step();
        rst = 1'b0; start = 1'b0; ld_en = 1'b0;
        check("rst_beats_start", busy, 1'b0);
        step();
        run_prog(5'd3, 1'b0);
        check_run("indep", 3, 5, 0);
        issue_at("indep_s0", 0, 1, a0);
        issue_at("indep_s1", 1, 2, a1);
        issue_at("indep_s2", 2, 3, a2);

        // Load and start attempted mid-run are ignored.
        run_prog(5'd3, 1'b1);
        check_run("poke", 3, 5, 0);
        run_prog(5'd3, 1'b0);
        issue_at("poke_slot0_kept", 0, 1, a0);

        // Back-to-back RAW hazard.
        load(4'd0, b0); load(4'd1, b1);
        run_prog(5'd2, 1'b0);
        check_run("raw1", 2, B_DONE, B_STALL);
        issue_at("raw1_s0", 0, 1, b0);
        issue_at("raw1_s1", 1, B_K1, b1);

        // Distance-2 hazard; stall_cnt restarts from zero.
        load(4'd0, c0); load(4'd1, c1); load(4'd2, c2);
        run_prog(5'd3, 1'b0);
        check_run("raw2", 3, C_DONE, C_STALL);
        issue_at("raw2_s0", 0, 1, c0);
        issue_at("raw2_s1", 1, 2, c1);
        issue_at("raw2_s2", 2, C_K2, c2);

        // Empty program: done right after start, nothing issued.
        run_prog(5'd0, 1'b0);
        check_run("len0", 0, 0, 0);

        // Oversized length clamps to a full 16-slot program.
        for (int i = 0; i < 16; i++) begin
            load(4'(i), mk(4'(i), 4'd1, 4'd2, 4'd3, 8'h40 + 8'(i)));
        end
        run_prog(5'd20, 1'b0);
        check_run("len20", 16, 18, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= iss_k.size()) bad++;
            else if (iss_k[i] != i + 1 ||
                     iss_w[i] !== mk(4'(i), 4'd1, 4'd2, 4'd3, 8'h40 + 8'(i))) bad++;
        end
        check("len20_order", bad, 0);

        // Reset during the stall window aborts without done; rerun is clean.
        load(4'd0, b0); load(4'd1, b1);
        prog_len = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b1; start = 1'b1;
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 24'hFFFFFF;
        step();
        check("abort_busy",      busy, 1'b0);
        check("abort_outs_zero", |{func, rs1, rs2, rd, addr, issue_valid, done}, 1'b0);
        check("abort_stall_cnt", stall_cnt, 8'h0);
        rst = 1'b0; start = 1'b0; ld_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        check("abort_no_done", seen, 0);
        run_prog(5'd2, 1'b0);
        check_run("rerun", 2, B_DONE, B_STALL);
        issue_at("rerun_s0", 0, 1, b0);
        issue_at("rerun_s1", 1, B_K1, b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
